// File: rtl/pic_host_pkg.sv
// pic_host_pkg: state/step encodings, EOI word and ICW bit positions shared by
// the PIC host sequencer and its bench.
`default_nettype none

package pic_host_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_WR_SETUP  = 4'd1,
    ST_WR_STROBE = 4'd2,
    ST_WR_GAP    = 4'd3,
    ST_ACK1      = 4'd4,
    ST_ACK_GAP   = 4'd5,
    ST_ACK2      = 4'd6,
    ST_VEC       = 4'd7
  } state_t;

  typedef enum logic [2:0] {
    STEP_ICW1 = 3'd0,
    STEP_ICW2 = 3'd1,
    STEP_ICW3 = 3'd2,
    STEP_ICW4 = 3'd3,
    STEP_OCW1 = 3'd4,
    STEP_EOI  = 3'd5
  } step_t;

  localparam logic [7:0] c_EOI_WORD  = 8'h20;
  localparam int         c_ICW1_IC4  = 0;
  localparam int         c_ICW1_SNGL = 1;
  localparam int         c_ICW4_AEOI = 1;

  // Next init word after the current one; ICW3 only in cascade, ICW4 only if IC4.
  function automatic step_t next_init_step(input step_t step, input logic [1:0] icw1_lo);
    step_t nxt;
    nxt = STEP_OCW1;
    case (step)
      STEP_ICW1: nxt = STEP_ICW2;
      STEP_ICW2: nxt = !icw1_lo[c_ICW1_SNGL] ? STEP_ICW3 :
                       (icw1_lo[c_ICW1_IC4] ? STEP_ICW4 : STEP_OCW1);
      STEP_ICW3: nxt = icw1_lo[c_ICW1_IC4] ? STEP_ICW4 : STEP_OCW1;
      default:   nxt = STEP_OCW1;
    endcase
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pic_strobe_timer.sv
// pic_strobe_timer: loadable 4-bit down-counter; a phase loaded with N-1
// reports done on its N-th cycle.
`default_nettype none

module pic_strobe_timer (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  output logic       o_done
);

  logic [3:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_done = (r_cnt == 4'd0);

endmodule

`default_nettype wire

// File: rtl/pic_host_sequencer.sv
// pic_host_sequencer: drives 8259 init writes and the INTA vector fetch.
// Optional automatic EOI after each vector: define PIC_HOST_AUTO_EOI_EN.
`default_nettype none

module pic_host_sequencer
  import pic_host_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES    = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [7:0] i_icw1,
  input  logic [7:0] i_icw2,
  input  logic [7:0] i_icw3,
  input  logic [7:0] i_icw4,
  input  logic [7:0] i_ocw1,
  input  logic       i_int,
  input  logic [7:0] i_data_in,
  output logic [7:0] o_data_out,
  output logic       o_data_oe,
  output logic       o_a0,
  output logic       o_wr_n,
  output logic       o_rd_n,
  output logic       o_inta_n,
  output logic [7:0] o_vector,
  output logic       o_vector_valid,
  output logic       o_busy,
  output logic       o_init_done
);

  localparam logic [3:0] c_STROBE_LD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] c_GAP_LD    = 4'(GAP_CYCLES - 1);

  state_t     r_state, w_state_nxt;
  step_t      r_step, w_step_nxt;
  logic [7:0] r_icw1, r_icw2, r_icw3, r_icw4, r_ocw1;
  logic [7:0] r_vector;
  logic       r_init_done;
  logic       w_latch, w_capture, w_set_done;
  logic       w_tmr_load, w_tmr_done;
  logic [3:0] w_tmr_val;
  logic [7:0] w_word;

  pic_strobe_timer u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_step  <= STEP_ICW1;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_latch     = 1'b0;
    w_capture   = 1'b0;
    w_set_done  = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_val   = c_STROBE_LD;
    case (r_state)
      ST_IDLE: begin
        // START has priority over a pending interrupt and forces re-init.
        if (i_start) begin
          w_latch     = 1'b1;
          w_step_nxt  = STEP_ICW1;
          w_state_nxt = ST_WR_SETUP;
        end else if (r_init_done && i_int) begin
          w_tmr_load  = 1'b1;
          w_state_nxt = ST_ACK1;
        end
      end
      ST_WR_SETUP: begin
        w_tmr_load  = 1'b1;
        w_state_nxt = ST_WR_STROBE;
      end
      ST_WR_STROBE: begin
        if (w_tmr_done) begin
          w_tmr_load  = 1'b1;
          w_tmr_val   = c_GAP_LD;
          w_state_nxt = ST_WR_GAP;
        end
      end
      ST_WR_GAP: begin
        if (w_tmr_done) begin
          if (r_step == STEP_OCW1) begin
            w_set_done  = 1'b1;
            w_state_nxt = ST_IDLE;
`ifdef PIC_HOST_AUTO_EOI_EN
          end else if (r_step == STEP_EOI) begin
            w_state_nxt = ST_IDLE;
`endif
          end else begin
            w_step_nxt  = next_init_step(r_step, r_icw1[1:0]);
            w_state_nxt = ST_WR_SETUP;
          end
        end
      end
      ST_ACK1: begin
        if (w_tmr_done) begin
          w_tmr_load  = 1'b1;
          w_tmr_val   = c_GAP_LD;
          w_state_nxt = ST_ACK_GAP;
        end
      end
      ST_ACK_GAP: begin
        if (w_tmr_done) begin
          w_tmr_load  = 1'b1;
          w_state_nxt = ST_ACK2;
        end
      end
      ST_ACK2: begin
        if (w_tmr_done) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_VEC;
        end
      end
      ST_VEC: begin
        w_state_nxt = ST_IDLE;
`ifdef PIC_HOST_AUTO_EOI_EN
        if (r_icw1[c_ICW1_IC4] && !r_icw4[c_ICW4_AEOI]) begin
          w_step_nxt  = STEP_EOI;
          w_state_nxt = ST_WR_SETUP;
        end
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_icw1      <= 8'h00;
      r_icw2      <= 8'h00;
      r_icw3      <= 8'h00;
      r_icw4      <= 8'h00;
      r_ocw1      <= 8'h00;
      r_vector    <= 8'h00;
      r_init_done <= 1'b0;
    end else begin
      if (w_latch) begin
        r_icw1      <= i_icw1;
        r_icw2      <= i_icw2;
        r_icw3      <= i_icw3;
        r_icw4      <= i_icw4;
        r_ocw1      <= i_ocw1;
        r_init_done <= 1'b0;
      end else if (w_set_done) begin
        r_init_done <= 1'b1;
      end
      if (w_capture) begin
        r_vector <= i_data_in;
      end
    end
  end

  always_comb begin
    w_word = 8'h00;
    case (r_step)
      STEP_ICW1: w_word = r_icw1;
      STEP_ICW2: w_word = r_icw2;
      STEP_ICW3: w_word = r_icw3;
      STEP_ICW4: w_word = r_icw4;
      STEP_OCW1: w_word = r_ocw1;
`ifdef PIC_HOST_AUTO_EOI_EN
      STEP_EOI:  w_word = c_EOI_WORD;
`endif
      default:   w_word = 8'h00;
    endcase
  end

  assign o_data_oe      = (r_state == ST_WR_SETUP) || (r_state == ST_WR_STROBE);
  assign o_data_out     = o_data_oe ? w_word : 8'h00;
  assign o_a0           = ((r_state == ST_WR_SETUP) || (r_state == ST_WR_STROBE) ||
                           (r_state == ST_WR_GAP)) &&
                          (r_step != STEP_ICW1) && (r_step != STEP_EOI);
  assign o_wr_n         = (r_state != ST_WR_STROBE);
  assign o_inta_n       = (r_state != ST_ACK1) && (r_state != ST_ACK2);
  assign o_rd_n         = (r_state != ST_ACK2);
  assign o_vector       = r_vector;
  assign o_vector_valid = (r_state == ST_VEC);
  assign o_busy         = (r_state != ST_IDLE);
  assign o_init_done    = r_init_done;

endmodule

`default_nettype wire

// File: tb/tb_pic_host_sequencer.sv
// tb_pic_host_sequencer: directed scenario bench for pic_host_sequencer
// (STROBE_CYCLES=2, GAP_CYCLES=1; EOI expectations follow PIC_HOST_AUTO_EOI_EN).
`default_nettype none

module tb_pic_host_sequencer;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_start = 1'b0;
  logic [7:0] i_icw1 = 8'h00, i_icw2 = 8'h00, i_icw3 = 8'h00, i_icw4 = 8'h00, i_ocw1 = 8'h00;
  logic       i_int = 1'b0;
  logic [7:0] i_data_in = 8'h55;
  logic [7:0] o_data_out, o_vector;
  logic       o_data_oe, o_a0, o_wr_n, o_rd_n, o_inta_n, o_vector_valid, o_busy, o_init_done;

  always #5 clk = ~clk;

  pic_host_sequencer #(.STROBE_CYCLES(2), .GAP_CYCLES(1)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start),
    .i_icw1(i_icw1), .i_icw2(i_icw2), .i_icw3(i_icw3), .i_icw4(i_icw4), .i_ocw1(i_ocw1),
    .i_int(i_int), .i_data_in(i_data_in),
    .o_data_out(o_data_out), .o_data_oe(o_data_oe), .o_a0(o_a0),
    .o_wr_n(o_wr_n), .o_rd_n(o_rd_n), .o_inta_n(o_inta_n),
    .o_vector(o_vector), .o_vector_valid(o_vector_valid),
    .o_busy(o_busy), .o_init_done(o_init_done)
  );

  int tests = 0;
  int fails = 0;

  logic       cap_a0[8];
  logic [7:0] cap_data[8];
  int         cap_wr_w[8], cap_inta_w[8], cap_rd_w[8];
  logic       cap_inta_rd[8];
  int         n_wr, n_wr_w, n_inta, n_inta_w, n_rd_w;
  int         vv_cycles, busy_cycles, oe_viol;
  logic [7:0] vv_value;
  bit         timed_out;

  // Observe one busy episode from the current negedge until BUSY drops.
  // Acts as the PIC: drives the vector while RD_ is low and drops INT once acked.
  task automatic capture(input logic [7:0] vec, input bit hold_int, input int max_cycles);
    logic pw, pi, pr;
    int   lw, li, lr;
    pw = 1'b1; pi = 1'b1; pr = 1'b1; lw = 0; li = 0; lr = 0;
    n_wr = 0; n_wr_w = 0; n_inta = 0; n_inta_w = 0; n_rd_w = 0;
    vv_cycles = 0; busy_cycles = 0; oe_viol = 0; vv_value = 8'hxx; timed_out = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cap_a0[k] = 1'bx; cap_data[k] = 8'hxx; cap_inta_rd[k] = 1'bx;
      cap_wr_w[k] = -1; cap_inta_w[k] = -1; cap_rd_w[k] = -1;
    end
    for (int i = 0; i < max_cycles; i++) begin
      if (i == 0 && !hold_int) i_int = 1'b0;
      i_data_in = o_rd_n ? 8'h55 : vec;
      if (!o_busy) begin
        timed_out = 1'b0;
        break;
      end
      busy_cycles++;
      if (!o_wr_n && pw && n_wr < 8) begin
        cap_a0[n_wr] = o_a0; cap_data[n_wr] = o_data_out; n_wr++;
      end
      if (!o_inta_n && pi && n_inta < 8) begin
        cap_inta_rd[n_inta] = o_rd_n; n_inta++;
      end
      if (!o_wr_n) lw++;
      else if (!pw) begin if (n_wr_w < 8) cap_wr_w[n_wr_w] = lw; n_wr_w++; lw = 0; end
      if (!o_inta_n) li++;
      else if (!pi) begin if (n_inta_w < 8) cap_inta_w[n_inta_w] = li; n_inta_w++; li = 0; end
      if (!o_rd_n) lr++;
      else if (!pr) begin if (n_rd_w < 8) cap_rd_w[n_rd_w] = lr; n_rd_w++; lr = 0; end
      if ((o_data_oe && !o_rd_n) || (!o_data_oe && !o_wr_n)) oe_viol++;
      if (o_vector_valid) begin vv_cycles++; vv_value = o_vector; end
      pw = o_wr_n; pi = o_inta_n; pr = o_rd_n;
      @(negedge clk);
    end
  endtask

  task automatic do_start(input logic [7:0] w1, input logic [7:0] w2, input logic [7:0] w3,
                          input logic [7:0] w4, input logic [7:0] wo);
    @(negedge clk);
    i_icw1 = w1; i_icw2 = w2; i_icw3 = w3; i_icw4 = w4; i_ocw1 = wo;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if ({o_wr_n, o_rd_n, o_inta_n, o_a0, o_data_oe, o_vector_valid, o_busy, o_init_done} !== 8'b1110_0000) begin
      fails++; $display("FAIL reset_ctrl: got %b want 11100000", {o_wr_n, o_rd_n, o_inta_n, o_a0, o_data_oe, o_vector_valid, o_busy, o_init_done}); end
    tests++; if (o_data_out !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", o_data_out); end
    tests++; if (o_vector !== 8'h00) begin fails++; $display("FAIL reset_vector: got %h want 00", o_vector); end
    i_reset = 1'b0;
  endtask

  task automatic test_int_ignored();
    int busy_seen;
    busy_seen = 0;
    i_int = 1'b1;
    repeat (6) begin @(negedge clk); if (o_busy || !o_inta_n) busy_seen++; end
    i_int = 1'b0;
    tests++; if (busy_seen !== 0) begin fails++; $display("FAIL int_before_init: busy cycles %0d want 0", busy_seen); end
  endtask

  task automatic test_init_icw4();
    logic [8:0] exp[4];
    exp = '{9'h013, 9'h1F8, 9'h121, 9'h100};
    do_start(8'h13, 8'hF8, 8'h77, 8'h21, 8'h00);
    capture(8'h00, 1'b1, 100);
    tests++; if (timed_out) begin fails++; $display("FAIL init4_timeout: busy never dropped"); end
    tests++; if (n_wr !== 4) begin fails++; $display("FAIL init4_count: got %0d writes want 4", n_wr); end
    for (int k = 0; k < 4; k++) begin
      tests++; if ({cap_a0[k], cap_data[k]} !== exp[k]) begin
        fails++; $display("FAIL init4_write%0d: got a0/data %h want %h", k, {cap_a0[k], cap_data[k]}, exp[k]); end
      tests++; if (cap_wr_w[k] !== 2) begin fails++; $display("FAIL init4_width%0d: got %0d want 2", k, cap_wr_w[k]); end
    end
    tests++; if (busy_cycles !== 16) begin fails++; $display("FAIL init4_cycles: got %0d want 16", busy_cycles); end
    tests++; if (oe_viol !== 0) begin fails++; $display("FAIL init4_oe: got %0d bad cycles want 0", oe_viol); end
    tests++; if (o_init_done !== 1'b1) begin fails++; $display("FAIL init4_done: got %b want 1", o_init_done); end
  endtask

  task automatic test_init_icw3();
    logic [8:0] exp[4];
    exp = '{9'h010, 9'h140, 9'h104, 9'h1FE};
    do_start(8'h10, 8'h40, 8'h04, 8'hAA, 8'hFE);
    capture(8'h00, 1'b1, 100);
    tests++; if (n_wr !== 4 || timed_out) begin fails++; $display("FAIL init3_count: got %0d writes timeout=%0d want 4/0", n_wr, timed_out); end
    for (int k = 0; k < 4; k++) begin
      tests++; if ({cap_a0[k], cap_data[k]} !== exp[k]) begin
        fails++; $display("FAIL init3_write%0d: got a0/data %h want %h", k, {cap_a0[k], cap_data[k]}, exp[k]); end
    end
    tests++; if (o_init_done !== 1'b1) begin fails++; $display("FAIL init3_done: got %b want 1", o_init_done); end
  endtask

  task automatic test_interrupt();
    @(negedge clk); i_int = 1'b1;
    @(negedge clk);
    capture(8'hFA, 1'b0, 50);
    tests++; if (n_inta !== 2 || cap_inta_w[0] !== 2 || cap_inta_w[1] !== 2) begin
      fails++; $display("FAIL intr_inta: got %0d pulses widths %0d,%0d want 2 pulses of 2", n_inta, cap_inta_w[0], cap_inta_w[1]); end
    tests++; if ({cap_inta_rd[0], cap_inta_rd[1]} !== 2'b10) begin
      fails++; $display("FAIL intr_rd_phase: got rd_n %b want 10", {cap_inta_rd[0], cap_inta_rd[1]}); end
    tests++; if (n_rd_w !== 1 || cap_rd_w[0] !== 2) begin
      fails++; $display("FAIL intr_rd: got %0d pulses width %0d want 1 of 2", n_rd_w, cap_rd_w[0]); end
    tests++; if (vv_cycles !== 1 || vv_value !== 8'hFA) begin
      fails++; $display("FAIL intr_valid: got %0d cycles value %h want 1 FA", vv_cycles, vv_value); end
    tests++; if (o_vector !== 8'hFA) begin fails++; $display("FAIL intr_vector: got %h want FA", o_vector); end
    tests++; if (busy_cycles !== 6 || n_wr !== 0) begin
      fails++; $display("FAIL intr_cycles: got %0d cycles %0d writes want 6 0", busy_cycles, n_wr); end
    tests++; if (oe_viol !== 0) begin fails++; $display("FAIL intr_oe: got %0d bad cycles want 0", oe_viol); end
  endtask

  task automatic test_auto_eoi();
    int exp_wr, exp_busy;
`ifdef PIC_HOST_AUTO_EOI_EN
    exp_wr = 1; exp_busy = 10;
`else
    exp_wr = 0; exp_busy = 6;
`endif
    do_start(8'h13, 8'hF8, 8'h00, 8'h21, 8'h00);
    capture(8'h00, 1'b1, 100);
    @(negedge clk); i_int = 1'b1;
    @(negedge clk);
    capture(8'hC4, 1'b0, 50);
    tests++; if (n_wr !== exp_wr || busy_cycles !== exp_busy) begin
      fails++; $display("FAIL eoi_count: got %0d writes %0d cycles want %0d %0d", n_wr, busy_cycles, exp_wr, exp_busy); end
    if (exp_wr == 1) begin
      tests++; if ({cap_a0[0], cap_data[0]} !== 9'h020) begin
        fails++; $display("FAIL eoi_word: got a0/data %h want 020", {cap_a0[0], cap_data[0]}); end
    end
    tests++; if (vv_value !== 8'hC4) begin fails++; $display("FAIL eoi_vector: got %h want C4", vv_value); end
    do_start(8'h13, 8'hF8, 8'h00, 8'h23, 8'h00);
    capture(8'h00, 1'b1, 100);
    @(negedge clk); i_int = 1'b1;
    @(negedge clk);
    capture(8'h91, 1'b0, 50);
    tests++; if (n_wr !== 0 || busy_cycles !== 6) begin
      fails++; $display("FAIL aeoi_count: got %0d writes %0d cycles want 0 6", n_wr, busy_cycles); end
  endtask

  task automatic test_start_during_ack();
    @(negedge clk); i_int = 1'b1;
    @(negedge clk);
    i_icw1 = 8'h10; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    capture(8'h3C, 1'b0, 50);
    tests++; if (n_wr !== 0 || busy_cycles !== 5) begin
      fails++; $display("FAIL ackstart_cycles: got %0d writes %0d cycles want 0 5", n_wr, busy_cycles); end
    tests++; if (vv_cycles !== 1 || vv_value !== 8'h3C) begin
      fails++; $display("FAIL ackstart_vector: got %0d cycles value %h want 1 3C", vv_cycles, vv_value); end
    tests++; if (o_init_done !== 1'b1) begin fails++; $display("FAIL ackstart_done: got %b want 1", o_init_done); end
  endtask

  task automatic test_start_and_int();
    logic [8:0] exp[4];
    exp = '{9'h013, 9'h108, 9'h123, 9'h15A};
    @(negedge clk);
    i_icw1 = 8'h13; i_icw2 = 8'h08; i_icw3 = 8'h00; i_icw4 = 8'h23; i_ocw1 = 8'h5A;
    i_start = 1'b1; i_int = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    tests++; if ({o_init_done, o_busy, o_inta_n} !== 3'b011) begin
      fails++; $display("FAIL both_first: got done/busy/inta_n %b want 011", {o_init_done, o_busy, o_inta_n}); end
    capture(8'h00, 1'b1, 100);
    tests++; if (n_wr !== 4 || n_inta !== 0 || busy_cycles !== 16) begin
      fails++; $display("FAIL both_init: got %0d writes %0d inta %0d cycles want 4 0 16", n_wr, n_inta, busy_cycles); end
    for (int k = 0; k < 4; k++) begin
      tests++; if ({cap_a0[k], cap_data[k]} !== exp[k]) begin
        fails++; $display("FAIL both_write%0d: got a0/data %h want %h", k, {cap_a0[k], cap_data[k]}, exp[k]); end
    end
    @(negedge clk);
    capture(8'h77, 1'b0, 50);
    tests++; if (vv_cycles !== 1 || vv_value !== 8'h77 || busy_cycles !== 6) begin
      fails++; $display("FAIL both_ack: got %0d valid value %h %0d cycles want 1 77 6", vv_cycles, vv_value, busy_cycles); end
  endtask

  task automatic test_reset_mid_strobe();
    do_start(8'h13, 8'hF8, 8'h00, 8'h21, 8'h00);
    repeat (5) @(negedge clk);
    tests++; if ({o_wr_n, o_a0, o_data_out} !== 10'h1F8) begin
      fails++; $display("FAIL midrst_pre: got wr_n/a0/data %h want 0F8 pattern", {o_wr_n, o_a0, o_data_out}); end
    #2 i_reset = 1'b1;
    #1;
    tests++; if ({o_wr_n, o_rd_n, o_inta_n, o_a0, o_data_oe, o_vector_valid, o_busy, o_init_done} !== 8'b1110_0000) begin
      fails++; $display("FAIL midrst_ctrl: got %b want 11100000", {o_wr_n, o_rd_n, o_inta_n, o_a0, o_data_oe, o_vector_valid, o_busy, o_init_done}); end
    tests++; if (o_data_out !== 8'h00 || o_vector !== 8'h00) begin
      fails++; $display("FAIL midrst_data: got data %h vector %h want 00 00", o_data_out, o_vector); end
    @(negedge clk);
    i_reset = 1'b0;
    do_start(8'h13, 8'hF8, 8'h00, 8'h21, 8'h00);
    capture(8'h00, 1'b1, 100);
    tests++; if (n_wr !== 4 || {cap_a0[0], cap_data[0]} !== 9'h013 || o_init_done !== 1'b1) begin
      fails++; $display("FAIL midrst_restart: got %0d writes first %h done %b want 4 013 1", n_wr, {cap_a0[0], cap_data[0]}, o_init_done); end
  endtask

  initial begin
    test_reset();
    test_int_ignored();
    test_init_icw4();
    test_init_icw3();
    test_interrupt();
    test_auto_eoi();
    test_start_during_ack();
    test_start_and_int();
    test_reset_mid_strobe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
